// File: rtl/shape_cmd_queue.sv
// rtl/shape_cmd_queue.sv - command FIFO and read/write sequencer for the shape processor register port
// Commands replay strictly in order; a read stalls the queue while a response is still pending.
module shape_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             write,
  output logic [31:0]      write_data,
  output logic             read,
  input  logic [31:0]      read_data,
  input  logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE} state_t;

  state_t        state, state_n;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [32:0]   head;
  logic          ready_q;
  logic          push, pop, issue_wr, issue_rd, capture;

  // ready_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = ready_q && (count < DEPTH_C);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || (state != IDLE) || write || read;

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (head[32]) begin
            pop      = 1'b1;
            issue_wr = 1'b1;
          end else if (!rsp_valid) begin
            pop      = 1'b1;
            issue_rd = 1'b1;
            state_n  = RD_ISSUE;
          end
        end
      end
      RD_ISSUE:   state_n = RD_CAPTURE;
      RD_CAPTURE: begin
        capture = 1'b1;
        state_n = IDLE;
      end
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_write, cmd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write      <= 1'b0;
      read       <= 1'b0;
      write_data <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      err_count  <= '0;
    end else begin
      write <= issue_wr;
      read  <= issue_rd;
      if (issue_wr) write_data <= head[31:0];
      if (capture) begin
        rsp_data  <= read_data;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (error && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule
